fetch_instruction: RTL and testbench

Instruction-fetch stage of the 3-stage pipeline. Holds the program counter (PC), drives it as the instruction-memory address, and latches the returned word into the instruction register (IR) for the decode stage. Instruction memory sits outside the block and is combinational: the word for the current address is valid within the same cycle.

---
 rtl/fetch_instruction.sv | 41 ++++
 tb/tb_fetch_instruction.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_instruction.sv
// Instruction-fetch stage: PC register drives instruction memory, IR latches the returned word.
// Optional FETCH_REDIRECT_EN adds stall / redirect control of the PC.
module fetch_instruction #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] curr_instr
`ifdef FETCH_REDIRECT_EN
  ,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr
`endif
);

  // PC and IR update; redirect inserts a NOP bubble, stall freezes both registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_addr <= '0;
      curr_instr <= '0;
    end else begin
`ifdef FETCH_REDIRECT_EN
      if (redirect) begin
        instr_addr <= redirect_addr;
        curr_instr <= '0;
      end else if (!stall) begin
        instr_addr <= instr_addr + ADDR_W'(1);
        curr_instr <= instr;
      end
`else
      instr_addr <= instr_addr + ADDR_W'(1);
      curr_instr <= instr;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_instruction.sv
// Scoreboard bench for fetch_instruction; memory model returns {addr, ~addr}.
module tb_fetch_instruction;

  logic        clk;
  logic        rst;
  logic [7:0]  instr_addr;
  logic [15:0] instr;
  logic [15:0] curr_instr;
`ifdef FETCH_REDIRECT_EN
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_addr;
`endif

  int checks;
  int errors;

  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [23:0] sb_q[$];

  fetch_instruction #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_addr (instr_addr),
    .instr      (instr),
    .curr_instr (curr_instr)
`ifdef FETCH_REDIRECT_EN
    ,
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr)
`endif
  );

  assign instr = {instr_addr, ~instr_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model one edge, push the expectation, then compare at the falling edge.
  task automatic step(input string name);
    logic [23:0] exp;
    logic        do_stall;
    logic        do_redir;
    logic [7:0]  raddr;
    do_stall = 1'b0;
    do_redir = 1'b0;
    raddr    = 8'h00;
`ifdef FETCH_REDIRECT_EN
    do_stall = stall;
    do_redir = redirect;
    raddr    = redirect_addr;
`endif
    if (do_redir) begin
      m_pc = raddr;
      m_ir = 16'h0000;
    end else if (!do_stall) begin
      m_ir = {m_pc, ~m_pc};
      m_pc = m_pc + 8'd1;
    end
    sb_q.push_back({m_pc, m_ir});
    @(posedge clk);
    @(negedge clk);
    exp = sb_q.pop_front();
    checks++;
    if (instr_addr !== exp[23:16]) begin
      errors++;
      $display("FAIL %s addr: got %h want %h", name, instr_addr, exp[23:16]);
    end
    checks++;
    if (curr_instr !== exp[15:0]) begin
      errors++;
      $display("FAIL %s ir: got %h want %h", name, curr_instr, exp[15:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (instr_addr !== 8'h00 || curr_instr !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold: got %h/%h want 00/0000", instr_addr, curr_instr);
      end
    end
    rst  = 1'b0;
    m_pc = 8'h00;
    m_ir = 16'h0000;
  endtask

  task automatic test_seq_fetch();
    for (int k = 1; k <= 10; k++) step("seq");
    checks++;
    if (curr_instr !== 16'h090F6 >> 0 && curr_instr !== 16'h09F6) begin
      errors++;
      $display("FAIL seq_last_ir: got %h want 09f6", curr_instr);
    end
  endtask

  task automatic test_wrap();
    while (m_pc != 8'hFF) step("wrap_run");
    step("wrap_edge");
    checks++;
    if (instr_addr !== 8'h00 || curr_instr !== 16'hFF00) begin
      errors++;
      $display("FAIL wrap: got %h/%h want 00/ff00", instr_addr, curr_instr);
    end
  endtask

  task automatic test_mid_reset();
    while (m_pc != 8'h37) step("pre_reset");
    #1 rst = 1'b1;
    #1;
    checks++;
    if (instr_addr !== 8'h00 || curr_instr !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_async: got %h/%h want 00/0000", instr_addr, curr_instr);
    end
    @(negedge clk);
    rst  = 1'b0;
    m_pc = 8'h00;
    m_ir = 16'h0000;
    step("post_reset");
    checks++;
    if (instr_addr !== 8'h01 || curr_instr !== 16'h00FF) begin
      errors++;
      $display("FAIL restart: got %h/%h want 01/00ff", instr_addr, curr_instr);
    end
  endtask

  task automatic test_per_edge();
    for (int i = 0; i < 275; i++) step("per_edge");
  endtask

`ifdef FETCH_REDIRECT_EN
  task automatic test_stall();
    while (m_pc != 8'h10) step("pre_stall");
    stall = 1'b1;
    step("stall1");
    step("stall2");
    stall = 1'b0;
    step("unstall");
  endtask

  task automatic test_redirect();
    stall         = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 8'h80;
    step("redirect");
    checks++;
    if (instr_addr !== 8'h80 || curr_instr !== 16'h0000) begin
      errors++;
      $display("FAIL redirect_bubble: got %h/%h want 80/0000", instr_addr, curr_instr);
    end
    stall    = 1'b0;
    redirect = 1'b0;
    step("after_redirect");
    checks++;
    if (instr_addr !== 8'h81 || curr_instr !== 16'h807F) begin
      errors++;
      $display("FAIL redirect_target: got %h/%h want 81/807f", instr_addr, curr_instr);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    m_pc   = 8'h00;
    m_ir   = 16'h0000;
`ifdef FETCH_REDIRECT_EN
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 8'h00;
`endif
    @(negedge clk);
    test_reset();
    test_seq_fetch();
    test_wrap();
    test_mid_reset();
    test_per_edge();
`ifdef FETCH_REDIRECT_EN
    test_stall();
    test_redirect();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
